// File: rtl/rotor_step_ctrl.sv
// Enigma M3 rotor sequencer: accepts a keypress, double-steps the rotors, waits for the
// scrambler to settle, then returns the enciphered letter on a valid/ready output.
module rotor_step_ctrl #(
    parameter int unsigned NOTCH_R    = 21,
    parameter int unsigned NOTCH_M    = 4,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       load_en,
    input  logic [4:0] load_pos_l,
    input  logic [4:0] load_pos_m,
    input  logic [4:0] load_pos_r,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [4:0] key_code,
    output logic [4:0] pos_l,
    output logic [4:0] pos_m,
    output logic [4:0] pos_r,
    output logic [4:0] enc_key,
    input  logic [4:0] cipher_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_code,
    output logic       err
);

    localparam int unsigned PW      = 5;
    localparam int unsigned CW      = 4;
    localparam logic [PW-1:0] POS_MAX = PW'(25);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STEP   = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [PW-1:0]  r_pos_l, r_pos_m, r_pos_r;
    logic [PW-1:0]  w_pos_l_nxt, w_pos_m_nxt, w_pos_r_nxt;
    logic [PW-1:0]  r_enc_key, w_enc_key_nxt;
    logic [PW-1:0]  r_out_code, w_out_code_nxt;
    logic           r_out_valid, w_out_valid_nxt;
    logic           r_err, w_err_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic           w_load_ok;
    logic           w_notch_r;
    logic           w_notch_m;

    function automatic logic [PW-1:0] inc26(input logic [PW-1:0] p);
        return (p == POS_MAX) ? '0 : p + PW'(1);
    endfunction

    assign w_load_ok = (load_pos_l <= POS_MAX) && (load_pos_m <= POS_MAX) &&
                       (load_pos_r <= POS_MAX);
    assign w_notch_r = (r_pos_r == PW'(NOTCH_R));
    assign w_notch_m = (r_pos_m == PW'(NOTCH_M));

    // Next-state and next-register values; every register holds unless a branch updates it.
    always_comb begin
        w_state_nxt     = r_state;
        w_pos_l_nxt     = r_pos_l;
        w_pos_m_nxt     = r_pos_m;
        w_pos_r_nxt     = r_pos_r;
        w_enc_key_nxt   = r_enc_key;
        w_out_code_nxt  = r_out_code;
        w_out_valid_nxt = r_out_valid;
        w_cnt_nxt       = r_cnt;
        w_err_nxt       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (load_en) begin
                    if (w_load_ok) begin
                        w_pos_l_nxt = load_pos_l;
                        w_pos_m_nxt = load_pos_m;
                        w_pos_r_nxt = load_pos_r;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else if (key_valid) begin
                    if (key_code <= POS_MAX) begin
                        w_enc_key_nxt = key_code;
                        w_state_nxt   = S_STEP;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_STEP: begin
                // Double-step: the middle rotor also moves when it sits on its own notch.
                w_pos_r_nxt = inc26(r_pos_r);
                if (w_notch_r || w_notch_m) begin
                    w_pos_m_nxt = inc26(r_pos_m);
                end
                if (w_notch_m) begin
                    w_pos_l_nxt = inc26(r_pos_l);
                end
                w_cnt_nxt   = '0;
                w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_cnt == CW'(SETTLE_CYC - 1)) begin
                    w_out_code_nxt  = cipher_code;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (load_en && (r_state != S_IDLE)) begin
            w_err_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_pos_l     <= '0;
            r_pos_m     <= '0;
            r_pos_r     <= '0;
            r_enc_key   <= '0;
            r_out_code  <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pos_l     <= w_pos_l_nxt;
            r_pos_m     <= w_pos_m_nxt;
            r_pos_r     <= w_pos_r_nxt;
            r_enc_key   <= w_enc_key_nxt;
            r_out_code  <= w_out_code_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_err       <= w_err_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign key_ready = (r_state == S_IDLE) && !load_en;
    assign pos_l     = r_pos_l;
    assign pos_m     = r_pos_m;
    assign pos_r     = r_pos_r;
    assign enc_key   = r_enc_key;
    assign out_code  = r_out_code;
    assign out_valid = r_out_valid;
    assign err       = r_err;

endmodule

// File: tb/tb_rotor_step_ctrl.sv
// Bench for rotor_step_ctrl: a toy scrambler closes the loop; expected letters are queued
// at key issue and checked by monitors when each output handshake occurs.
module tb_rotor_step_ctrl;

    typedef struct packed {
        logic [4:0] code;
        logic [4:0] l;
        logic [4:0] m;
        logic [4:0] r;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       load_en = 1'b0, load_en_w = 1'b0;
    logic [4:0] load_pos_l = '0, load_pos_m = '0, load_pos_r = '0;
    logic       key_valid = 1'b0, key_valid_w = 1'b0;
    logic [4:0] key_code = '0;
    logic       out_ready = 1'b1;
    logic       out_ready_w = 1'b1;

    logic       key_ready, key_ready_w;
    logic [4:0] pos_l, pos_m, pos_r, pos_l_w, pos_m_w, pos_r_w;
    logic [4:0] enc_key, enc_key_w, cipher_code, cipher_code_w;
    logic       out_valid, out_valid_w, err, err_w;
    logic [4:0] out_code, out_code_w;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t q[$];
    exp_t q_w[$];
    exp_t mon_e, mon_ew;

    always #5 CLK = ~CLK;

    function automatic logic [4:0] scr(input logic [4:0] k, input logic [4:0] l,
                                       input logic [4:0] m, input logic [4:0] r);
        int s;
        s = (int'(k) + int'(r) + 2 * int'(m) + 3 * int'(l) + 7) % 26;
        return 5'(s);
    endfunction

    assign cipher_code   = scr(enc_key, pos_l, pos_m, pos_r);
    assign cipher_code_w = scr(enc_key_w, pos_l_w, pos_m_w, pos_r_w);

    rotor_step_ctrl dut (
        .CLK(CLK), .RST(RST), .load_en(load_en),
        .load_pos_l(load_pos_l), .load_pos_m(load_pos_m), .load_pos_r(load_pos_r),
        .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
        .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r), .enc_key(enc_key),
        .cipher_code(cipher_code), .out_valid(out_valid), .out_ready(out_ready),
        .out_code(out_code), .err(err)
    );

    rotor_step_ctrl #(.NOTCH_R(25), .NOTCH_M(25), .SETTLE_CYC(2)) dut_w (
        .CLK(CLK), .RST(RST), .load_en(load_en_w),
        .load_pos_l(load_pos_l), .load_pos_m(load_pos_m), .load_pos_r(load_pos_r),
        .key_valid(key_valid_w), .key_ready(key_ready_w), .key_code(key_code),
        .pos_l(pos_l_w), .pos_m(pos_m_w), .pos_r(pos_r_w), .enc_key(enc_key_w),
        .cipher_code(cipher_code_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
        .out_code(out_code_w), .err(err_w)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Scoreboard monitors: one pop per output handshake.
    always @(negedge CLK) begin
        if (!RST && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 32'(out_code), 32'd99);
            end else begin
                mon_e = q.pop_front();
                chk("out_code", 32'(out_code), 32'(mon_e.code));
                chk("out_pos_l", 32'(pos_l), 32'(mon_e.l));
                chk("out_pos_m", 32'(pos_m), 32'(mon_e.m));
                chk("out_pos_r", 32'(pos_r), 32'(mon_e.r));
            end
        end
    end

    always @(negedge CLK) begin
        if (!RST && out_valid_w && out_ready_w) begin
            if (q_w.size() == 0) begin
                chk("unexpected_out_w", 32'(out_code_w), 32'd99);
            end else begin
                mon_ew = q_w.pop_front();
                chk("out_code_w", 32'(out_code_w), 32'(mon_ew.code));
                chk("out_pos_l_w", 32'(pos_l_w), 32'(mon_ew.l));
                chk("out_pos_m_w", 32'(pos_m_w), 32'(mon_ew.m));
                chk("out_pos_r_w", 32'(pos_r_w), 32'(mon_ew.r));
            end
        end
    end

    task automatic wait_ready(input bit sel);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (sel ? key_ready_w : key_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("key_ready_timeout", 32'(ok), 32'd1);
    endtask

    task automatic do_load(input bit sel, input logic [4:0] l, input logic [4:0] m,
                           input logic [4:0] r);
        wait_ready(sel);
        @(posedge CLK); #1;
        load_pos_l = l; load_pos_m = m; load_pos_r = r;
        if (sel) load_en_w = 1'b1; else load_en = 1'b1;
        @(posedge CLK); #1;
        load_en = 1'b0; load_en_w = 1'b0;
    endtask

    task automatic do_key(input bit sel, input logic [4:0] k, input bit push,
                          input logic [4:0] el, input logic [4:0] em, input logic [4:0] er);
        exp_t e;
        wait_ready(sel);
        @(posedge CLK); #1;
        key_code = k;
        e = '{code: scr(k, el, em, er), l: el, m: em, r: er};
        if (sel) begin
            key_valid_w = 1'b1;
            if (push) q_w.push_back(e);
        end else begin
            key_valid = 1'b1;
            if (push) q.push_back(e);
        end
        @(posedge CLK); #1;
        key_valid = 1'b0; key_valid_w = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (q.size() != 0 || q_w.size() != 0); i++) @(negedge CLK);
        if (q.size() != 0 || q_w.size() != 0)
            chk("drain_timeout", 32'(q.size() + q_w.size()), 32'd0);
    endtask

    initial begin
        int  lat;
        bit  seen;
        logic [4:0] hold_code;

        // Reset
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_pos_l", 32'(pos_l), 32'd0);
        chk("rst_pos_m", 32'(pos_m), 32'd0);
        chk("rst_pos_r", 32'(pos_r), 32'd0);
        chk("rst_key_ready", 32'(key_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Right-rotor turnover plus latency
        do_load(0, 5'd0, 5'd0, 5'd21);
        @(negedge CLK);
        chk("load_pos_r", 32'(pos_r), 32'd21);
        do_key(0, 5'd0, 1, 5'd0, 5'd1, 5'd22);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge CLK);
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        chk("latency", 32'(lat), 32'd4);
        drain();

        // Double step
        do_load(0, 5'd0, 5'd3, 5'd21);
        do_key(0, 5'd11, 1, 5'd0, 5'd4, 5'd22);
        do_key(0, 5'd12, 1, 5'd1, 5'd5, 5'd23);
        do_key(0, 5'd13, 1, 5'd1, 5'd5, 5'd24);
        drain();

        // Backpressure in DONE
        @(posedge CLK); #1 out_ready = 1'b0;
        do_key(0, 5'd9, 1, 5'd1, 5'd5, 5'd25);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge CLK);
            seen = out_valid;
        end
        hold_code = scr(5'd9, 5'd1, 5'd5, 5'd25);
        for (int i = 0; i < 6; i++) begin
            if (i != 0) @(negedge CLK);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_code", 32'(out_code), 32'(hold_code));
            chk("bp_key_ready", 32'(key_ready), 32'd0);
            chk("bp_pos_r", 32'(pos_r), 32'd25);
            @(posedge CLK); #1;
            key_code  = 5'd2;
            key_valid = (i % 2 == 0);
        end
        @(posedge CLK); #1;
        key_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk("bp_release_key_ready", 32'(key_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_pos_r", 32'(pos_r), 32'd25);
        drain();

        // Illegal load value
        do_load(0, 5'd0, 5'd26, 5'd0);
        @(negedge CLK);
        chk("badload_err", 32'(err), 32'd1);
        chk("badload_pos_l", 32'(pos_l), 32'd1);
        chk("badload_pos_m", 32'(pos_m), 32'd5);
        chk("badload_pos_r", 32'(pos_r), 32'd25);
        @(negedge CLK);
        chk("badload_err_pulse", 32'(err), 32'd0);

        // Illegal key
        wait_ready(0);
        @(posedge CLK); #1;
        key_code = 5'd27; key_valid = 1'b1;
        @(posedge CLK); #1;
        key_valid = 1'b0;
        @(negedge CLK);
        chk("badkey_err", 32'(err), 32'd1);
        chk("badkey_key_ready", 32'(key_ready), 32'd1);
        chk("badkey_pos_r", 32'(pos_r), 32'd25);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            seen = seen | out_valid;
        end
        chk("badkey_no_out", 32'(seen), 32'd0);

        // load_en while busy: err pulse, letter still produced
        do_key(0, 5'd4, 1, 5'd1, 5'd5, 5'd0);
        @(posedge CLK); #1;
        load_pos_l = 5'd2; load_pos_m = 5'd2; load_pos_r = 5'd2;
        load_en = 1'b1;
        @(posedge CLK); #1;
        load_en = 1'b0;
        @(negedge CLK);
        chk("busyload_err", 32'(err), 32'd1);
        chk("busyload_pos_m", 32'(pos_m), 32'd5);
        drain();

        // Reset mid-SETTLE drops the letter
        do_key(0, 5'd7, 0, 5'd0, 5'd0, 5'd0);
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        chk("midrst_pos_l", 32'(pos_l), 32'd0);
        chk("midrst_pos_m", 32'(pos_m), 32'd0);
        chk("midrst_pos_r", 32'(pos_r), 32'd0);
        chk("midrst_key_ready", 32'(key_ready), 32'd1);
        seen = out_valid;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            seen = seen | out_valid;
        end
        chk("midrst_no_out", 32'(seen), 32'd0);

        // Full wrap of all three rotors
        do_load(1, 5'd25, 5'd25, 5'd25);
        @(negedge CLK);
        chk("wrap_load_pos_l", 32'(pos_l_w), 32'd25);
        do_key(1, 5'd3, 1, 5'd0, 5'd0, 5'd0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d checks expected completion", n_chk);
        $fatal(1, "timeout");
    end

endmodule
